// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with a small return-address stack.
// It handles redirects from EX, and call/return predictions from ID, with a registered PC.
module pc_unit_ras #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               INC          = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_stall,
    input  logic                         i_redirect_valid,
    input  logic [WIDTH-1:0]             i_redirect_target,
    input  logic                         i_call,
    input  logic [WIDTH-1:0]             i_call_target,
    input  logic                         i_ret,
    output logic [WIDTH-1:0]             o_pc_out,
    output logic                         o_pc_valid,
    output logic [$clog2(RAS_DEPTH):0]   o_ras_count,
    output logic                         o_ret_miss
);
    localparam int SP_W  = $clog2(RAS_DEPTH);
    localparam int CNT_W = SP_W + 1;

    logic [WIDTH-1:0] r_pc;
    logic             r_pc_valid;
    logic [SP_W-1:0]  r_sp;
    logic [CNT_W-1:0] r_count;
    logic             r_ret_miss;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];

    logic [WIDTH-1:0] w_inc_pc;
    logic [SP_W-1:0]  w_top_idx;
    logic [WIDTH-1:0] w_top;
    logic             w_empty;
    logic             w_full;

    logic [WIDTH-1:0] w_pc_next;
    logic [SP_W-1:0]  w_sp_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_miss_next;
    logic             w_wr_en;
    logic [SP_W-1:0]  w_wr_idx;

    assign w_inc_pc  = r_pc + WIDTH'(INC);
    assign w_top_idx = r_sp - SP_W'(1);
    assign w_top     = r_ras[w_top_idx];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(RAS_DEPTH));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_pc_next    = r_pc;
        w_sp_next    = r_sp;
        w_count_next = r_count;
        w_miss_next  = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_idx     = r_sp;
        // The first edge after reset only raises pc_valid; the PC starts moving on the next edge.
        if (r_pc_valid) begin
            if (i_redirect_valid) begin
                w_pc_next = i_redirect_target;
            end else if (!i_stall) begin
                if (i_call && i_ret && !w_empty) begin
                    w_pc_next = i_call_target;
                    w_wr_en   = 1'b1;
                    w_wr_idx  = w_top_idx;
                end else if (i_call) begin
                    // When the stack is full, sp already points at the oldest slot, so the push overwrites it.
                    w_pc_next    = i_call_target;
                    w_wr_en      = 1'b1;
                    w_sp_next    = r_sp + SP_W'(1);
                    w_count_next = w_full ? r_count : r_count + CNT_W'(1);
                end else if (i_ret && !w_empty) begin
                    w_pc_next    = w_top;
                    w_sp_next    = w_top_idx;
                    w_count_next = r_count - CNT_W'(1);
                end else if (i_ret) begin
                    w_pc_next   = w_inc_pc;
                    w_miss_next = 1'b1;
                end else begin
                    w_pc_next = w_inc_pc;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_VECTOR;
            r_pc_valid <= 1'b0;
            r_sp       <= '0;
            r_count    <= '0;
            r_ret_miss <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_pc_valid <= 1'b1;
            r_sp       <= w_sp_next;
            r_count    <= w_count_next;
            r_ret_miss <= w_miss_next;
        end
    end

    // NOTE: the stack storage has no reset; a slot is never read before it has been written.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_ras[w_wr_idx] <= w_inc_pc;
        end
    end

    assign o_pc_out    = r_pc;
    assign o_pc_valid  = r_pc_valid;
    assign o_ras_count = r_count;
    assign o_ret_miss  = r_ret_miss;
endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: directed scenarios, then randomized traffic.
// Results are compared against a queue-based return-stack model.
module tb_pc_unit_ras;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stall, i_redirect_valid, i_call, i_ret;
    logic [31:0] i_redirect_target, i_call_target;
    logic [31:0] o_pc_out;
    logic        o_pc_valid, o_ret_miss;
    logic [2:0]  o_ras_count;

    pc_unit_ras #(.WIDTH(32), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .i_stall(i_stall), .i_redirect_valid(i_redirect_valid),
        .i_redirect_target(i_redirect_target), .i_call(i_call),
        .i_call_target(i_call_target), .i_ret(i_ret),
        .o_pc_out(o_pc_out), .o_pc_valid(o_pc_valid),
        .o_ras_count(o_ras_count), .o_ret_miss(o_ret_miss)
    );

    always #5 clk = ~clk;

    // Reference model: the return stack is a queue, newest entry at the back.
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_miss;
    logic [31:0] m_ras[$];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    o_pc_out,                 m_pc);
        check({tag, ".valid"}, {31'b0, o_pc_valid},      {31'b0, m_valid});
        check({tag, ".count"}, {29'b0, o_ras_count},     32'(m_ras.size()));
        check({tag, ".miss"},  {31'b0, o_ret_miss},      {31'b0, m_miss});
    endtask

    task automatic model_edge(input bit st, input bit rv, input logic [31:0] rt,
                              input bit c, input logic [31:0] ct, input bit r);
        logic [31:0] nxt;
        nxt    = m_pc + 32'd4;
        m_miss = 1'b0;
        if (!m_valid) begin
            m_valid = 1'b1;
        end else if (rv) begin
            m_pc = rt;
        end else if (st) begin
            m_pc = m_pc;
        end else if (c && r && m_ras.size() > 0) begin
            m_ras[m_ras.size()-1] = nxt;
            m_pc = ct;
        end else if (c) begin
            m_ras.push_back(nxt);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            m_pc = ct;
        end else if (r && m_ras.size() > 0) begin
            m_pc = m_ras.pop_back();
        end else if (r) begin
            m_pc   = nxt;
            m_miss = 1'b1;
        end else begin
            m_pc = nxt;
        end
    endtask

    // One clock: drive the inputs, take the edge, sample 1 ns later, and compare with the model.
    task automatic step(input string tag, input bit st, input bit rv, input logic [31:0] rt,
                        input bit c, input logic [31:0] ct, input bit r);
        i_stall = st; i_redirect_valid = rv; i_redirect_target = rt;
        i_call = c; i_call_target = ct; i_ret = r;
        @(posedge clk);
        #1;
        model_edge(st, rv, rt, c, ct, r);
        check_all(tag);
    endtask

    task automatic free(input string tag);
        step(tag, 0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic redirect(input string tag, input logic [31:0] t);
        step(tag, 0, 1, t, 0, 32'h0, 0);
    endtask

    // Reset is raised asynchronously, away from the edge, and is checked before any clock arrives.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        m_pc = 32'h0; m_valid = 1'b0; m_miss = 1'b0; m_ras.delete();
        check_all(tag);
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        i_stall = 0; i_redirect_valid = 0; i_redirect_target = 0;
        i_call = 0; i_call_target = 0; i_ret = 0;
        rst = 1'b0;
        m_pc = 32'h0; m_valid = 1'b0; m_miss = 1'b0;
        #2;
        async_reset("por");
        free("por.e1"); free("por.e2"); free("por.e3");

        // Reach pc=0x40 with two live entries, then reset mid-run.
        step("t1.call_a", 0, 0, 0, 1, 32'h38, 0);
        step("t1.call_b", 0, 0, 0, 1, 32'h40, 0);
        #2;
        async_reset("t1.rst");
        free("t1.e1"); free("t1.e2"); free("t1.e3");

        // Stall holds the PC; a redirect overrides the stall.
        redirect("t2.goto", 32'h10);
        step("t2.stall1", 1, 0, 0, 0, 0, 0);
        step("t2.stall2", 1, 0, 0, 1, 32'h999, 1);
        step("t2.stall_redir", 1, 1, 32'h200, 0, 0, 0);

        // A call followed by a return comes back to the fall-through address.
        redirect("t3.goto", 32'h20);
        step("t3.call", 0, 0, 0, 1, 32'h100, 0);
        step("t3.ret",  0, 0, 0, 0, 0, 1);

        // Overflow of the stack: five calls, four returns, then one return that misses.
        redirect("t4.goto", 32'h0);
        for (int k = 0; k < 5; k++) step($sformatf("t4.call%0d", k), 0, 0, 0, 1, m_pc + 32'h100, 0);
        for (int k = 0; k < 4; k++) step($sformatf("t4.ret%0d", k), 0, 0, 0, 0, 0, 1);
        step("t4.ret_empty", 0, 0, 0, 0, 0, 1);
        free("t4.after");

        // A call and a return on the same edge replace the top entry.
        redirect("t5.goto", 32'h10);
        step("t5.call", 0, 0, 0, 1, 32'h50, 0);
        step("t5.callret", 0, 0, 0, 1, 32'h300, 1);
        step("t5.callret_redir", 0, 1, 32'h800, 1, 32'h300, 1);
        step("t5.ret_top", 0, 0, 0, 0, 0, 1);

        // The PC wraps past the top of the address space.
        redirect("t6.goto", 32'hFFFF_FFFC);
        free("t6.wrap");

        // Random traffic, with an occasional asynchronous reset.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(59) == 0) begin
                #2;
                async_reset($sformatf("rnd%0d.rst", k));
            end else begin
                step($sformatf("rnd%0d", k),
                     $urandom_range(5) == 0,
                     $urandom_range(9) == 0, $urandom & 32'hFFFF_FFFC,
                     $urandom_range(3) == 0, $urandom & 32'hFFFF_FFFC,
                     $urandom_range(3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
